// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock through a ripple full adder, result after WIDTH cycles.
// Optional subtract mode is compiled in when SERIAL_ADDER_SUB_EN is defined (adds the sub port).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_full;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             carry_init;
    logic             accept;
    logic             last;
    logic             b_bit;
    logic             ha1_s, ha1_c, ha2_s, ha2_c;
    logic             fa_s, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_r;
    assign b_bit      = b_sr[0] ^ sub_r;
    assign carry_init = sub;
`else
    assign b_bit      = b_sr[0];
    assign carry_init = 1'b0;
`endif

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Full adder as two cascaded half adders.
    assign ha1_s = a_sr[0] ^ b_bit;
    assign ha1_c = a_sr[0] & b_bit;
    assign ha2_s = ha1_s ^ carry;
    assign ha2_c = ha1_s & carry;
    assign fa_s  = ha2_s;
    assign fa_c  = ha1_c | ha2_c;

    // The newest sum bit enters at the MSB; after the last bit the whole word is aligned.
    assign res_full = {fa_s, res_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = DONE;
            DONE: state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            carry  <= carry_init;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r  <= sub;
`endif
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_full[WIDTH-1:1];
            carry  <= fa_c;
            cnt    <= cnt + 1'b1;
            // carry still holds the carry into the MSB on the final bit.
            if (last) begin
                sum  <= res_full;
                cout <= fa_c;
                ovf  <= carry ^ fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) using a scoreboard queue of expected results.
// Subtraction cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   full;
        exp_t         e;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic s_eff;
        a     = x;
        b     = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = s;
        s_eff = s;
`else
        s_eff = 1'b0 & s;
`endif
        start = 1'b1;
        sb.push_back(model(x, y, s_eff));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected 0", {busy, done, sum, cout, ovf});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        exp_t         e;
        logic [W-1:0] prev_sum;
        prev_sum = sum;
        launch(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < W; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) begin
                errors++;
                $display("[TB] FAIL latency_run[%0d]: got busy=%b done=%b sum=%h expected busy=1 done=0 sum=%h",
                         i, busy, done, sum, prev_sum);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_done: got busy=%b done=%b expected busy=0 done=1", busy, done);
        end
        checks++;
        if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("[TB] FAIL latency_result: got %h/%b/%b expected %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse_width: got busy=%b done=%b expected busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta [10];
        logic [W-1:0] tb [10];
        exp_t         e;
        int           cyc;
        bit           seen;
        ta[0] = 8'hFF; tb[0] = 8'h01;
        ta[1] = 8'h7F; tb[1] = 8'h01;
        ta[2] = 8'h80; tb[2] = 8'h80;
        ta[3] = 8'h00; tb[3] = 8'h00;
        for (int i = 4; i < 10; i++) begin
            ta[i] = W'($urandom_range(0, 255));
            tb[i] = W'($urandom_range(0, 255));
        end
        for (int i = 0; i < 10; i++) begin
            launch(ta[i], tb[i], 1'b0);
            wait_done(cyc, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || cyc != W) begin
                errors++;
                $display("[TB] FAIL arith_timing[%0d]: got seen=%b cycles=%0d expected seen=1 cycles=%0d", i, seen, cyc, W);
            end
            checks++;
            if ({sum, cout, ovf} !== e) begin
                errors++;
                $display("[TB] FAIL arith_result[%0d] %h+%h: got %h/%b/%b expected %h/%b/%b",
                         i, ta[i], tb[i], sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        int   cyc;
        bit   seen;
        launch(8'h30, 8'h22, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b1;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != W - 3) begin
            errors++;
            $display("[TB] FAIL ignore_timing: got seen=%b cycles=%0d expected seen=1 cycles=%0d", seen, cyc, W - 3);
        end
        checks++;
        if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("[TB] FAIL ignore_result: got %h/%b/%b expected %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
    endtask

    // Entered at the negedge where done is high, so this start is accepted from DONE.
    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   seen;
        launch(8'h40, 8'h45, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_no_gap: got busy=%b expected busy=1", busy);
        end
        wait_done(cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != W) begin
            errors++;
            $display("[TB] FAIL b2b_timing: got seen=%b cycles=%0d expected seen=1 cycles=%0d", seen, cyc, W);
        end
        checks++;
        if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("[TB] FAIL b2b_result: got %h/%b/%b expected %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        bit   seen;
        bit   stray_done;
        launch(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected 0", {busy, done, sum, cout, ovf});
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        stray_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) stray_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stray_done) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet: got activity after abort expected none");
        end
        launch(8'h12, 8'h34, 1'b0);
        wait_done(cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != W) begin
            errors++;
            $display("[TB] FAIL reset_mid_timing: got seen=%b cycles=%0d expected seen=1 cycles=%0d", seen, cyc, W);
        end
        checks++;
        if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid_result: got %h/%b/%b expected %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         ts [4];
        exp_t         e;
        int           cyc;
        bit           seen;
        ta[0] = 8'h05; tb[0] = 8'h07; ts[0] = 1'b1;
        ta[1] = 8'h80; tb[1] = 8'h01; ts[1] = 1'b1;
        ta[2] = 8'h33; tb[2] = 8'h33; ts[2] = 1'b1;
        ta[3] = 8'h05; tb[3] = 8'h07; ts[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], ts[i]);
            wait_done(cyc, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || {sum, cout, ovf} !== e) begin
                errors++;
                $display("[TB] FAIL sub_result[%0d]: got seen=%b %h/%b/%b expected %h/%b/%b",
                         i, seen, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            @(negedge clk);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
